// File: rtl/parity_serial_tx.sv
// parity_serial_tx: accepts a parallel word over valid/ready, registers its
// parity (odd, even or none) and sends a framed serial stream: start bit,
// data LSB first, optional parity bit, then 1 or 2 stop bits. Each bit lasts
// CLKS_PER_BIT system clocks. Every output is registered. The output
// registers are loaded from the next-state values, so each output changes on
// the same edge as the state it belongs to.
module parity_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 200_000_000
) (
  input  logic              clk,
  input  logic              resetSW_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              parity_bit,
  output logic              frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST  = IDX_W'(STOP_BITS - 1);

  if ((DATA_W < 1) || (DATA_W > 32)) begin : g_bad_data_w
    $error("parity_serial_tx: DATA_W must be 1..32");
  end
  if ((PARITY_MODE < 0) || (PARITY_MODE > 2)) begin : g_bad_parity_mode
    $error("parity_serial_tx: PARITY_MODE must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("parity_serial_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("parity_serial_tx: CLKS_PER_BIT must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit for the selected mode; zero when no parity bit is sent.
  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
    logic p;
    case (PARITY_MODE)
      1:       p = ~^d;
      2:       p = ^d;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_shift;
  logic               r_parity;
  logic               r_tx_ready;
  logic               r_serial_out;
  logic               r_busy;
  logic               r_frame_done;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [DATA_W-1:0]  w_shift_nxt;
  logic               w_parity_nxt;
  logic               w_cnt_last;
  logic               w_serial_nxt;
  logic               w_frame_done_nxt;

  // Next-state, bit counter, index and shift register logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_cnt_last   = (r_cnt == CNT_LAST);
    case (r_state)
      S_IDLE: begin
        if (tx_valid && r_tx_ready) begin
          w_state_nxt  = S_START;
          w_cnt_nxt    = {CNT_W{1'b0}};
          w_idx_nxt    = {IDX_W{1'b0}};
          w_shift_nxt  = tx_data;
          w_parity_nxt = calc_parity(tx_data);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_cnt_last) begin
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_idx_nxt   = {IDX_W{1'b0}};
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_DATA: begin
        if (w_cnt_last) begin
          w_cnt_nxt = {CNT_W{1'b0}};
          if (r_idx == IDX_DATA_LAST) begin
            w_idx_nxt   = {IDX_W{1'b0}};
            w_state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            w_idx_nxt   = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
            w_shift_nxt = r_shift >> 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_PARITY: begin
        if (w_cnt_last) begin
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_idx_nxt   = {IDX_W{1'b0}};
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_STOP: begin
        if (w_cnt_last) begin
          w_cnt_nxt = {CNT_W{1'b0}};
          if (r_idx == IDX_STOP_LAST) begin
            w_idx_nxt   = {IDX_W{1'b0}};
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_idx_nxt   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Line level and end-of-frame flag for the state being entered.
  always_comb begin
    w_serial_nxt = 1'b1;
    case (w_state_nxt)
      S_IDLE:   w_serial_nxt = 1'b1;
      S_START:  w_serial_nxt = 1'b0;
      S_DATA:   w_serial_nxt = w_shift_nxt[0];
      S_PARITY: w_serial_nxt = w_parity_nxt;
      S_STOP:   w_serial_nxt = 1'b1;
      default:  w_serial_nxt = 1'b1;
    endcase
    w_frame_done_nxt = (w_state_nxt == S_STOP) && (w_cnt_nxt == CNT_LAST) &&
                       (w_idx_nxt == IDX_STOP_LAST);
  end

  // State register and datapath; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!resetSW_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_idx    <= {IDX_W{1'b0}};
      r_shift  <= {DATA_W{1'b0}};
      r_parity <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
    end
  end

  // Registered outputs, loaded from the next-state values.
  always_ff @(posedge clk) begin
    if (!resetSW_n) begin
      r_tx_ready   <= 1'b1;
      r_serial_out <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_tx_ready   <= (w_state_nxt == S_IDLE);
      r_serial_out <= w_serial_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign tx_ready   = r_tx_ready;
  assign serial_out = r_serial_out;
  assign busy       = r_busy;
  assign parity_bit = r_parity;
  assign frame_done = r_frame_done;

endmodule
